// File: rtl/ddr_arbiter_pkg.sv
// Shared types and constants for the DDR MIG arbiter and its read-return tracker.
package ddr_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD} arb_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int         ADDR_STEP = 8;
  localparam int         DATA_W    = 128;

  // Address of the final word in a frame; both address pointers wrap after it.
  function automatic int frame_last_addr(input int frame_words);
    return (frame_words - 1) * ADDR_STEP;
  endfunction

endpackage

// File: rtl/ddr_read_tracker.sv
// Outstanding-read credits, one-cycle return register and frame-position tlast.
module ddr_read_tracker
  import ddr_arbiter_pkg::*;
#(
  parameter int FRAME_WORDS     = 1024,
  parameter int MAX_OUTSTANDING = 32,
  parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              issue,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_data,
  output logic [OUT_W-1:0]  outstanding,
  output logic              rd_axis_tvalid,
  output logic [DATA_W-1:0] rd_axis_tdata,
  output logic              rd_axis_tlast
);

  localparam int IDX_W = $clog2(FRAME_WORDS);

  logic [IDX_W-1:0] ret_idx;
  logic             ret_acc;
  logic             ret_last;

  // With no credit outstanding the data cannot belong to us (e.g. issued before reset).
  assign ret_acc  = ret_valid && (outstanding != '0);
  assign ret_last = (ret_idx == IDX_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      outstanding    <= '0;
      ret_idx        <= '0;
      rd_axis_tvalid <= 1'b0;
      rd_axis_tdata  <= '0;
      rd_axis_tlast  <= 1'b0;
    end else begin
      case ({issue, ret_acc})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      rd_axis_tvalid <= ret_acc;
      rd_axis_tlast  <= ret_acc && ret_last;
      if (ret_acc) begin
        rd_axis_tdata <= ret_data;
        ret_idx       <= ret_last ? '0 : ret_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Shares the MIG app_* port between an inbound write stream and a frame read stream
// in bounded alternating bursts. Define DDR_ARBITER_STATS_EN for command/stall counters.
module ddr_arbiter
  import ddr_arbiter_pkg::*;
#(
  parameter int FRAME_WORDS     = 1024,
  parameter int BURST           = 16,
  parameter int MAX_OUTSTANDING = 32,
  parameter int ADDR_W          = 27
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              init_calib_complete,
  input  logic              rd_enable_in,
  input  logic              wr_axis_tvalid,
  output logic              wr_axis_tready,
  input  logic [127:0]      wr_axis_tdata,
  input  logic              wr_axis_tlast,
  output logic              rd_axis_tvalid,
  output logic [127:0]      rd_axis_tdata,
  output logic              rd_axis_tlast,
  input  logic              rd_axis_prog_full,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid
`ifdef DDR_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_wr_cmds,
  output logic [31:0]       stat_rd_cmds,
  output logic [31:0]       stat_stall
`endif
);

  localparam int BCNT_W = $clog2(BURST + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(frame_last_addr(FRAME_WORDS));
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST - 1);

  arb_state_t        state, state_nxt;
  arb_state_t        last_grant, last_nxt;
  logic [BCNT_W-1:0] burst_cnt, bcnt_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [OUT_W-1:0]  outstanding;
  logic              wr_pend, rd_pend;
  logic              wr_fire, rd_fire;

  assign wr_pend     = wr_axis_tvalid;
  assign rd_pend     = rd_enable_in && !rd_axis_prog_full && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign app_wdf_end = 1'b1;

  always_comb begin
    state_nxt      = state;
    last_nxt       = last_grant;
    bcnt_nxt       = burst_cnt;
    app_en         = 1'b0;
    app_cmd        = CMD_WRITE;
    app_addr       = '0;
    app_wdf_data   = '0;
    app_wdf_wren   = 1'b0;
    wr_axis_tready = 1'b0;
    wr_fire        = 1'b0;
    rd_fire        = 1'b0;
    case (state)
      IDLE: begin
        bcnt_nxt = '0;
        if (init_calib_complete) begin
          if (wr_pend && (last_grant == RD || !rd_pend)) begin
            state_nxt = WR;
            last_nxt  = WR;
          end else if (rd_pend) begin
            state_nxt = RD;
            last_nxt  = RD;
          end
        end
      end
      WR: begin
        // Only strobe when MIG can take command and data together, so nothing is half-issued.
        wr_fire        = wr_axis_tvalid && app_rdy && app_wdf_rdy;
        app_en         = wr_fire;
        app_wdf_wren   = wr_fire;
        wr_axis_tready = wr_fire;
        app_addr       = wr_addr;
        app_wdf_data   = wr_axis_tdata;
        if (wr_fire) begin
          bcnt_nxt = burst_cnt + BCNT_W'(1);
          if (burst_cnt == LAST_BEAT) state_nxt = IDLE;
        end else if (!wr_pend) begin
          state_nxt = IDLE;
        end
      end
      RD: begin
        app_en   = rd_pend;
        app_cmd  = CMD_READ;
        app_addr = rd_addr;
        rd_fire  = rd_pend && app_rdy;
        if (rd_fire) begin
          bcnt_nxt = burst_cnt + BCNT_W'(1);
          if (burst_cnt == LAST_BEAT) state_nxt = IDLE;
        end else if (!rd_pend) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      last_grant <= RD;
      burst_cnt  <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      burst_cnt  <= bcnt_nxt;
      // tlast realigns the write pointer even on a short frame.
      if (wr_fire) wr_addr <= (wr_axis_tlast || wr_addr == LAST_ADDR) ? '0 : wr_addr + STEP;
      if (rd_fire) rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + STEP;
    end
  end

  ddr_read_tracker #(
    .FRAME_WORDS    (FRAME_WORDS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .OUT_W          (OUT_W)
  ) u_rd_trk (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .issue         (rd_fire),
    .ret_valid     (app_rd_data_valid),
    .ret_data      (app_rd_data),
    .outstanding   (outstanding),
    .rd_axis_tvalid(rd_axis_tvalid),
    .rd_axis_tdata (rd_axis_tdata),
    .rd_axis_tlast (rd_axis_tlast)
  );

`ifdef DDR_ARBITER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_wr_cmds <= '0;
      stat_rd_cmds <= '0;
      stat_stall   <= '0;
    end else begin
      if (wr_fire && stat_wr_cmds != '1) stat_wr_cmds <= stat_wr_cmds + 32'd1;
      if (rd_fire && stat_rd_cmds != '1) stat_rd_cmds <= stat_rd_cmds + 32'd1;
      if (app_en && !app_rdy && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
